// File: rtl/link_pkg.sv
// Shared constants and types for the board-to-board link.
package link_pkg;

  localparam int unsigned LINK_DATA_W = 9;
  localparam int unsigned REQ_BIT     = 10;
  localparam int unsigned ACK_BIT     = 9;
  localparam int unsigned PAYLOAD_MSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_ACK
  } tx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous partner-board inputs.
module sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/board_link.sv
// Board-to-board link: 9-bit words each way over a two-phase req/ack toggle handshake,
// with input synchronisation and a link-health indicator.
module board_link
  import link_pkg::*;
#(
  parameter int unsigned DATA_W         = LINK_DATA_W,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 750_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] check_in,
  output logic [DATA_W+1:0] check_out,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              link_up
);

  localparam int unsigned BusW   = DATA_W + 2;
  localparam int unsigned ReqBit = DATA_W + 1;
  localparam int unsigned AckBit = DATA_W;
  localparam int unsigned SetupW = $clog2(SETUP_CYCLES + 1);
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  logic [BusW-1:0] in_sync;

  sync2 #(
    .Width(BusW)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (check_in),
    .q_o   (in_sync)
  );

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic              req_q, req_d;
  logic              ack_q, ack_d;
  logic              req_seen_q, req_seen_d;
  logic [SetupW-1:0] setup_cnt_q, setup_cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              link_up_q, link_up_d;
  logic              tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_detect;

  assign rx_detect = in_sync[ReqBit] != req_seen_q;

  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    req_d       = req_q;
    ack_d       = ack_q;
    req_seen_d  = req_seen_q;
    setup_cnt_d = setup_cnt_q;
    timer_d     = timer_q;
    link_up_d   = link_up_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (tx_valid && tx_ready_q) begin
          payload_d   = tx_data;
          setup_cnt_d = '0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt_q == SetupW'(SETUP_CYCLES)) begin
          req_d   = ~req_q;
          timer_d = '0;
          state_d = WAIT_ACK;
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (in_sync[AckBit] == req_q) begin
          state_d   = IDLE;
          link_up_d = 1'b1;
          timer_d   = '0;
        end else if (timer_q != TimerW'(TIMEOUT_CYCLES)) begin
          timer_d = timer_q + 1'b1;
          // Drop only on the cycle the limit is reached so later RX activity can restore it.
          if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
            link_up_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rx_detect) begin
      rx_data_d  = in_sync[DATA_W-1:0];
      rx_valid_d = 1'b1;
      req_seen_d = ~req_seen_q;
      ack_d      = ~ack_q;
      link_up_d  = 1'b1;
    end

    tx_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      payload_q   <= '0;
      req_q       <= 1'b0;
      ack_q       <= 1'b0;
      req_seen_q  <= 1'b0;
      setup_cnt_q <= '0;
      timer_q     <= '0;
      link_up_q   <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      req_q       <= req_d;
      ack_q       <= ack_d;
      req_seen_q  <= req_seen_d;
      setup_cnt_q <= setup_cnt_d;
      timer_q     <= timer_d;
      link_up_q   <= link_up_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign check_out = {req_q, ack_q, payload_q};
  assign tx_ready  = tx_ready_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign link_up   = link_up_q;

endmodule

// File: tb/tb_board_link.sv
// Two cross-wired board_link instances exercised with directed steps and a word scoreboard.
module tb_board_link;
  import link_pkg::*;

  localparam int unsigned DW      = 9;
  localparam int unsigned SETUP   = 2;
  localparam int unsigned TIMEOUT = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst_n, b_rst_n, b_kill;
  logic [DW+1:0] a_check_in, a_check_out, b_check_in, b_check_out;
  logic [DW-1:0] a_tx_data, b_tx_data, a_rx_data, b_rx_data;
  logic          a_tx_valid, b_tx_valid, a_tx_ready, b_tx_ready;
  logic          a_rx_valid, b_rx_valid, a_link_up, b_link_up;

  assign a_check_in = b_check_out;
  assign b_check_in = b_kill ? '0 : a_check_out;

  board_link #(.DATA_W(DW), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TIMEOUT)) u_a (
    .clk(clk), .rst_n(a_rst_n), .check_in(a_check_in), .check_out(a_check_out),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .link_up(a_link_up)
  );

  board_link #(.DATA_W(DW), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TIMEOUT)) u_b (
    .clk(clk), .rst_n(b_rst_n), .check_in(b_check_in), .check_out(b_check_out),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .link_up(b_link_up)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q_ab[$];
  logic [DW-1:0] q_ba[$];
  int            a_rx_cnt = 0;
  int            b_rx_cnt = 0;
  logic          a_req_model = 1'b0;
  logic          b_req_model = 1'b0;
  logic [DW-1:0] last_b_word = '0;

  logic          mon_en = 1'b0;
  int            req_flips;
  logic          prev_req, prev_ready;
  logic [DW-1:0] prev_payload;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Scoreboard: every received word must be the oldest outstanding one in that direction.
  always @(negedge clk) begin
    if (a_rx_valid) begin
      a_rx_cnt++;
      chk("a_rx_expected", 32'(q_ba.size() != 0), 32'd1);
      if (q_ba.size() != 0) chk("a_rx_data", 32'(a_rx_data), 32'(q_ba.pop_front()));
    end
    if (b_rx_valid) begin
      b_rx_cnt++;
      chk("b_rx_expected", 32'(q_ab.size() != 0), 32'd1);
      if (q_ab.size() != 0) chk("b_rx_data", 32'(b_rx_data), 32'(q_ab.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (a_check_out[REQ_BIT] != prev_req) req_flips++;
      if (!prev_ready && !a_tx_ready)
        chk("pin_stable", 32'(a_check_out[PAYLOAD_MSB:0]), 32'(prev_payload));
      prev_req     = a_check_out[REQ_BIT];
      prev_ready   = a_tx_ready;
      prev_payload = a_check_out[PAYLOAD_MSB:0];
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_a(input logic [DW-1:0] w);
    int n = 0;
    a_tx_data  = w;
    a_tx_valid = 1'b1;
    q_ab.push_back(w);
    a_req_model = ~a_req_model;
    while (!a_tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("a_accept_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
    a_tx_valid = 1'b0;
  endtask

  task automatic send_b(input logic [DW-1:0] w);
    int n = 0;
    b_tx_data  = w;
    b_tx_valid = 1'b1;
    q_ba.push_back(w);
    b_req_model = ~b_req_model;
    last_b_word = w;
    while (!b_tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_accept_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
    b_tx_valid = 1'b0;
  endtask

  task automatic wait_a_idle(input string tag);
    int n = 0;
    while (!a_tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  // Keeps our req at 0 so the partner's req_seen is 0 before a fault is injected.
  task automatic align_a_req();
    if (a_req_model) begin
      send_a(9'h055);
      wait_a_idle("align_idle");
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int bcnt;
    int acc;
    logic v;
    logic [DW-1:0] d;

    a_rst_n = 1'b0; b_rst_n = 1'b0; b_kill = 1'b0;
    a_tx_data = '0; b_tx_data = '0; a_tx_valid = 1'b0; b_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_check_out", 32'(a_check_out), 32'd0);
    chk("rst_b_check_out", 32'(b_check_out), 32'd0);
    chk("rst_a_rx_data", 32'(a_rx_data), 32'd0);
    chk("rst_a_rx_valid", 32'(a_rx_valid), 32'd0);
    chk("rst_a_link_up", 32'(a_link_up), 32'd0);
    chk("rst_b_link_up", 32'(b_link_up), 32'd0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    chk("rel_a_tx_ready", 32'(a_tx_ready), 32'd1);
    chk("rel_b_tx_ready", 32'(b_tx_ready), 32'd1);

    // Single word; accept cycle counted as the first of the round trip.
    send_a(9'h1A5);
    c = 0;
    while (!a_tx_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("single_round_trip", 32'(c + 1), 32'(SETUP + 8));
    repeat (5) @(negedge clk);
    chk("single_b_rx_cnt", 32'(b_rx_cnt), 32'd1);
    chk("single_b_rx_data", 32'(b_rx_data), 32'h1A5);
    chk("single_a_link_up", 32'(a_link_up), 32'd1);
    chk("single_b_link_up", 32'(b_link_up), 32'd1);

    // Back-to-back with tx_valid held.
    send_a(9'h001);
    send_a(9'h002);
    send_a(9'h003);
    wait_a_idle("b2b_idle");
    repeat (8) @(negedge clk);
    chk("b2b_drained", 32'(q_ab.size()), 32'd0);
    chk("b2b_b_rx_cnt", 32'(b_rx_cnt), 32'd4);
    chk("b2b_hold_003", 32'(b_rx_data), 32'h003);

    // Full duplex.
    fork
      send_a(9'h0F0);
      send_b(9'h10F);
    join
    c = 0;
    while (!(a_tx_ready && b_tx_ready) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("duplex_within_12", 32'(c + 1 <= 12), 32'd1);
    repeat (6) @(negedge clk);
    chk("duplex_a_rx_data", 32'(a_rx_data), 32'h10F);
    chk("duplex_b_rx_data", 32'(b_rx_data), 32'h0F0);
    chk("duplex_drained", 32'(q_ab.size() + q_ba.size()), 32'd0);

    // Timeout with the partner's input held at zero.
    align_a_req();
    b_kill = 1'b1;
    repeat (10) @(negedge clk);
    send_a(9'h0AA);
    c = 0;
    repeat (20) begin
      @(negedge clk);
      c++;
    end
    chk("to_link_still_up", 32'(a_link_up), 32'd1);
    chk("to_busy", 32'(a_tx_ready), 32'd0);
    while (a_link_up && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("to_drop_window", 32'(c >= TIMEOUT && c <= TIMEOUT + SETUP + 4), 32'd1);
    repeat (5) @(negedge clk);
    chk("to_no_abort", 32'(a_tx_ready), 32'd0);
    b_kill = 1'b0;
    wait_a_idle("to_recover_idle");
    chk("to_link_restored", 32'(a_link_up), 32'd1);
    repeat (8) @(negedge clk);
    chk("to_drained", 32'(q_ab.size()), 32'd0);

    // Local reset during SETUP.
    align_a_req();
    bcnt = b_rx_cnt;
    a_tx_data  = 9'h133;
    a_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    a_tx_valid = 1'b0;
    chk("rst_mid_in_setup", 32'(a_tx_ready), 32'd0);
    a_rst_n = 1'b0;
    #1;
    chk("rst_mid_check_out", 32'(a_check_out), 32'd0);
    chk("rst_mid_link_up", 32'(a_link_up), 32'd0);
    a_req_model = 1'b0;
    // A forgets req_seen, so the partner's last word is seen once more.
    if (b_req_model) q_ba.push_back(last_b_word);
    @(negedge clk);
    @(negedge clk);
    a_rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx_ready", 32'(a_tx_ready), 32'd1);
    repeat (20) @(negedge clk);
    chk("rst_mid_no_b_rx", 32'(b_rx_cnt), 32'(bcnt));
    chk("rst_mid_spurious_done", 32'(q_ba.size()), 32'd0);

    // Random tx_valid: payload stable while busy, one req flip per accepted word.
    @(posedge clk);
    #1;
    prev_req     = a_check_out[REQ_BIT];
    prev_ready   = a_tx_ready;
    prev_payload = a_check_out[PAYLOAD_MSB:0];
    req_flips    = 0;
    acc          = 0;
    mon_en       = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      v = 1'($urandom_range(0, 1));
      d = DW'($urandom);
      if (v && a_tx_ready) begin
        q_ab.push_back(d);
        acc++;
        a_req_model = ~a_req_model;
      end
      a_tx_valid = v;
      a_tx_data  = d;
    end
    @(negedge clk);
    a_tx_valid = 1'b0;
    wait_a_idle("rand_idle");
    repeat (8) @(negedge clk);
    mon_en = 1'b0;
    chk("rand_some_accepted", 32'(acc > 0), 32'd1);
    chk("rand_req_flips", 32'(req_flips), 32'(acc));
    chk("rand_drained", 32'(q_ab.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
